// File: rtl/button_repeat_conditioner.sv
// Button front end for a kitchen-timer style UI.
// Synchronises and debounces four raw buttons, then turns held min/sec presses into auto-repeating increment pulses.
module button_repeat_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 2500000,
    parameter int unsigned REPEAT_RATE     = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_modify,
    input  logic       button_min_raw,
    input  logic       button_sec_raw,
    input  logic       button_start_raw,
    output logic       min_inc,
    output logic       sec_inc,
    output logic       start_level,
    output logic       start_press,
    output logic [1:0] edit_state,
    output logic [3:0] debounced_levels
);

    localparam logic [31:0] DB_EFF = (DEBOUNCE_CYCLES == 0) ? 32'd1 : 32'(DEBOUNCE_CYCLES);
    localparam logic [31:0] RD_EFF = (REPEAT_DELAY == 0) ? 32'd1 : 32'(REPEAT_DELAY);
    localparam logic [31:0] RR_EFF = (REPEAT_RATE == 0) ? 32'd1 : 32'(REPEAT_RATE);

    // Bit order everywhere: 0 = min, 1 = sec, 2 = modify, 3 = start.
    localparam int MIN = 0;
    localparam int SEC = 1;
    localparam int MOD = 2;
    localparam int STA = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        DELAY  = 2'd2,
        REPEAT = 2'd3
    } state_t;

    logic [3:0]  raw_in;
    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  db_level;
    logic [31:0] db_cnt [4];
    logic [1:0]  db_prev;

    state_t      state;
    state_t      state_next;
    logic        owner_sec;
    logic        owner_next;
    logic [31:0] cnt;
    logic [31:0] cnt_next;
    logic        pulse;
    logic        owner_held;
    logic        min_rise;
    logic        sec_rise;
    logic        start_level_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign raw_in = {button_start_raw, button_modify, button_sec_raw, button_min_raw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // A level flips only after DB_EFF consecutive disagreeing samples; any agreement restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_level <= '0;
            db_prev  <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            db_prev <= db_level[1:0];
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DB_EFF - 32'd1) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= sat_inc(db_cnt[i]);
                end
            end
        end
    end

    // Presses are accepted only on a debounced rising edge, so a level already high when editing
    // becomes possible never starts an edit by itself.
    assign min_rise   = db_level[MIN] & ~db_prev[MIN];
    assign sec_rise   = db_level[SEC] & ~db_prev[SEC];
    assign owner_held = owner_sec ? db_level[SEC] : db_level[MIN];

    always_comb begin
        state_next = state;
        owner_next = owner_sec;
        cnt_next   = cnt;
        pulse      = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (db_level[MOD] && (sec_rise || min_rise)) begin
                    state_next = FIRST;
                    owner_next = sec_rise;
                    pulse      = 1'b1;
                end
            end
            default: begin
                if (!owner_held || !db_level[MOD]) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (state == FIRST) begin
                    state_next = DELAY;
                    cnt_next   = sat_inc(cnt);
                end else if (state == DELAY && cnt >= RD_EFF - 32'd1) begin
                    state_next = REPEAT;
                    cnt_next   = '0;
                    pulse      = 1'b1;
                end else if (state == REPEAT && cnt >= RR_EFF - 32'd1) begin
                    cnt_next = '0;
                    pulse    = 1'b1;
                end else begin
                    cnt_next = sat_inc(cnt);
                end
            end
        endcase
    end

    // Pulses are registered on the transition, so each is visible in the cycle it is issued
    // and the counter reads 0 in that same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            owner_sec     <= 1'b0;
            cnt           <= '0;
            min_inc       <= 1'b0;
            sec_inc       <= 1'b0;
            start_level   <= 1'b0;
            start_level_d <= 1'b0;
            start_press   <= 1'b0;
        end else begin
            state         <= state_next;
            owner_sec     <= owner_next;
            cnt           <= cnt_next;
            min_inc       <= pulse & ~owner_next;
            sec_inc       <= pulse & owner_next;
            start_level   <= db_level[STA];
            start_level_d <= start_level;
            start_press   <= start_level & ~start_level_d;
        end
    end

    assign edit_state       = state;
    assign debounced_levels = db_level;

endmodule
